// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and byte-lane helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD = '0;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_e;

  // Size code 3 is treated as a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: size_bytes = 3'd1;
      MEM_SIZE_H: size_bytes = 3'd2;
      default:    size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [1:0]  size,
                                              input logic        sign);
    case (size)
      MEM_SIZE_B: load_extend = {{24{sign & w[7]}}, w[7:0]};
      MEM_SIZE_H: load_extend = {{16{sign & w[15]}}, w[15:0]};
      default:    load_extend = w;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    get_byte = w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    put_byte = r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and load/store onto one byte-wide synchronous RAM,
// splitting accesses into little-endian byte cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_cancel,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_sign,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_e            state;
  owner_e            owner;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [2:0]        k_q;
  logic [2:0]        nbytes_q;
  logic              bubble_q;

  logic [ADDR_W-1:0] next_addr;
  logic [1:0]        slot;
  logic [31:0]       rd_word;
  logic              unused_addr_hi;

  // Only the low ADDR_W bits matter: the truncated add equals the low bits of the full add.
  assign unused_addr_hi = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  assign next_addr = addr_q + ADDR_W'(k_q + 3'd1);
  assign slot      = k_q[1:0] - 2'd1;

  // Byte returned this cycle belongs to the address issued one cycle earlier.
  always_comb begin
    rd_word = put_byte(buf_q, slot, ram_din);
  end

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      addr_q    <= '0;
      wdata_q   <= '0;
      buf_q     <= '0;
      size_q    <= '0;
      sign_q    <= DISABLE;
      k_q       <= '0;
      nbytes_q  <= '0;
      bubble_q  <= DISABLE;
      if_done   <= DISABLE;
      mem_done  <= DISABLE;
      if_inst   <= ZERO_WORD;
      mem_rdata <= ZERO_WORD;
      ram_addr  <= '0;
      ram_rw    <= DISABLE;
      ram_dout  <= '0;
    end else begin
      if_done  <= DISABLE;
      mem_done <= DISABLE;
      case (state)
        ST_IDLE: begin
          ram_rw   <= DISABLE;
          ram_addr <= '0;
          if (bubble_q) begin
            bubble_q <= DISABLE;
          end else if (mem_req) begin
            owner    <= OWN_MEM;
            addr_q   <= mem_addr[ADDR_W-1:0];
            wdata_q  <= mem_wdata;
            size_q   <= mem_size;
            sign_q   <= mem_sign;
            nbytes_q <= size_bytes(mem_size);
            k_q      <= '0;
            buf_q    <= ZERO_WORD;
            ram_addr <= mem_addr[ADDR_W-1:0];
            ram_rw   <= mem_we;
            ram_dout <= mem_wdata[7:0];
            state    <= mem_we ? ST_WR : ST_RD;
          end else if (if_req && !if_cancel) begin
            owner    <= OWN_IF;
            addr_q   <= if_addr[ADDR_W-1:0];
            size_q   <= MEM_SIZE_W;
            sign_q   <= DISABLE;
            nbytes_q <= 3'd4;
            k_q      <= '0;
            buf_q    <= ZERO_WORD;
            ram_addr <= if_addr[ADDR_W-1:0];
            ram_rw   <= DISABLE;
            state    <= ST_RD;
          end
        end

        ST_RD: begin
          ram_rw <= DISABLE;
          if (owner == OWN_IF && if_cancel) begin
            ram_addr <= '0;
            state    <= ST_IDLE;
          end else begin
            if (k_q != 3'd0) buf_q <= rd_word;
            if (k_q == nbytes_q) begin
              ram_addr <= '0;
              state    <= ST_DONE;
              if (owner == OWN_IF) begin
                if_inst <= rd_word;
                if_done <= ENABLE;
              end else begin
                mem_rdata <= load_extend(rd_word, size_q, sign_q);
                mem_done  <= ENABLE;
              end
            end else begin
              k_q      <= k_q + 3'd1;
              ram_addr <= (k_q + 3'd1 < nbytes_q) ? next_addr : '0;
            end
          end
        end

        ST_WR: begin
          if (k_q == nbytes_q - 3'd1) begin
            ram_rw   <= DISABLE;
            ram_addr <= '0;
            mem_done <= ENABLE;
            state    <= ST_DONE;
          end else begin
            k_q      <= k_q + 3'd1;
            ram_addr <= next_addr;
            ram_dout <= get_byte(wdata_q, k_q[1:0] + 2'd1);
          end
        end

        ST_DONE: begin
          ram_rw   <= DISABLE;
          ram_addr <= '0;
          bubble_q <= ENABLE;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
